// File: rtl/alu_sequencer.sv
// alu_sequencer: T0..T6 control-step sequencer for the single-bus datapath.
// Fetches one instruction over the memory read handshake, decodes the IR
// into one-hot register selects and an ALU op, then steps the strobes.
//
// Optional feature macro: ALU_SEQ_MULDIV_EN
//   defined     : MUL/DIV run as binary ops with a T6 HI write-back
//   not defined : MUL/DIV opcodes go to ERR; Zhighout/HIin/LOin tied 0
//
// Ports:
//   clock, clear (sync, active-low), start, ir[DATA_W], mem_ready
//   PCout, Zlowout, Zhighout, MDRout          bus-mux drive selects
//   MARin, PCin, MDRin, IRin, Yin, Zin        register load enables
//   IncPC, Read, HIin, LOin                   misc strobes
//   Rout/Rin[NUM_REGS]                        one-hot register selects
//   alu_op[OP_W]                              ALU op, nonzero in T4 only
//   busy, done, err                           status

module alu_sequencer #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int OP_W     = 5
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                start,
    input  logic [DATA_W-1:0]   ir,
    input  logic                mem_ready,
    output logic                PCout,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                MDRout,
    output logic                MARin,
    output logic                PCin,
    output logic                MDRin,
    output logic                IRin,
    output logic                Yin,
    output logic                Zin,
    output logic                IncPC,
    output logic                Read,
    output logic                HIin,
    output logic                LOin,
    output logic [NUM_REGS-1:0] Rout,
    output logic [NUM_REGS-1:0] Rin,
    output logic [OP_W-1:0]     alu_op,
    output logic                busy,
    output logic                done,
    output logic                err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
`ifdef ALU_SEQ_MULDIV_EN
        S_T6,
`endif
        S_ERR
    } state_t;

    typedef enum logic [1:0] {
        CL_ILL,
        CL_BIN,
        CL_UN,
        CL_MD
    } op_class_t;

    localparam logic [OP_W-1:0] OP_ADD = OP_W'(5'b00011);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(5'b00100);
    localparam logic [OP_W-1:0] OP_AND = OP_W'(5'b00101);
    localparam logic [OP_W-1:0] OP_OR  = OP_W'(5'b00110);
    localparam logic [OP_W-1:0] OP_SHR = OP_W'(5'b00111);
    localparam logic [OP_W-1:0] OP_SHL = OP_W'(5'b01000);
    localparam logic [OP_W-1:0] OP_ROR = OP_W'(5'b01001);
    localparam logic [OP_W-1:0] OP_ROL = OP_W'(5'b01010);
    localparam logic [OP_W-1:0] OP_NEG = OP_W'(5'b10001);
    localparam logic [OP_W-1:0] OP_NOT = OP_W'(5'b10010);
`ifdef ALU_SEQ_MULDIV_EN
    localparam logic [OP_W-1:0] OP_MUL = OP_W'(5'b01111);
    localparam logic [OP_W-1:0] OP_DIV = OP_W'(5'b10000);
`endif

    state_t          state_q, state_d;
    logic [OP_W-1:0] op_q, op_d;
    logic [3:0]      ra_q, ra_d;
    logic [3:0]      rb_q, rb_d;
    logic [3:0]      rc_q, rc_d;
    op_class_t       cls_q;
    op_class_t       cls_ir;

    // Only the opcode and register fields of the IR are consumed.
    logic unused_ir;
    assign unused_ir = ^ir;

    function automatic op_class_t op_class(input logic [OP_W-1:0] op);
        op_class_t c;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: c = CL_BIN;
            OP_NEG, OP_NOT:                 c = CL_UN;
`ifdef ALU_SEQ_MULDIV_EN
            OP_MUL, OP_DIV:                 c = CL_MD;
`endif
            default:                        c = CL_ILL;
        endcase
        return c;
    endfunction

    // Indices beyond the register file leave the select all-zero.
    function automatic logic [NUM_REGS-1:0] onehot(input logic [3:0] idx);
        logic [NUM_REGS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if ({28'd0, idx} == i) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    assign cls_ir = op_class(ir[31 -: OP_W]);
    assign cls_q  = op_class(op_q);

    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rc_q    <= rc_d;
        end
    end

    // Fields are captured on the edge that leaves T2.
    always_comb begin
        op_d = op_q;
        ra_d = ra_q;
        rb_d = rb_q;
        rc_d = rc_q;
        if (state_q == S_T2) begin
            op_d = ir[31 -: OP_W];
            ra_d = ir[26:23];
            rb_d = ir[22:19];
            rc_d = ir[18:15];
        end
    end

`ifndef ALU_SEQ_MULDIV_EN
    assign Zhighout = 1'b0;
    assign HIin     = 1'b0;
    assign LOin     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        PCout   = 1'b0;
        Zlowout = 1'b0;
        MDRout  = 1'b0;
        MARin   = 1'b0;
        PCin    = 1'b0;
        MDRin   = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        Zin     = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
        Zhighout = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
`endif
        Rout    = '0;
        Rin     = '0;
        alu_op  = '0;
        busy    = (state_q != S_IDLE);
        done    = 1'b0;
        err     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_T0;
                end
            end
            S_T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin     = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                // MDR loads only when the memory presents valid data.
                if (mem_ready) begin
                    MDRin   = 1'b1;
                    state_d = S_T2;
                end
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
                case (cls_ir)
                    CL_BIN,
                    CL_MD:   state_d = S_T3;
                    CL_UN:   state_d = S_T4;
                    default: state_d = S_ERR;
                endcase
            end
            S_T3: begin
                Rout    = onehot(rb_q);
                Yin     = 1'b1;
                state_d = S_T4;
            end
            S_T4: begin
                alu_op  = op_q;
                Zin     = 1'b1;
                // Unary ops take their single operand from Rb.
                if (cls_q == CL_UN) begin
                    Rout = onehot(rb_q);
                end else begin
                    Rout = onehot(rc_q);
                end
                state_d = S_T5;
            end
            S_T5: begin
                Zlowout = 1'b1;
`ifdef ALU_SEQ_MULDIV_EN
                if (cls_q == CL_MD) begin
                    LOin    = 1'b1;
                    state_d = S_T6;
                end else begin
                    Rin     = onehot(ra_q);
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
`else
                Rin     = onehot(ra_q);
                done    = 1'b1;
                state_d = S_IDLE;
`endif
            end
`ifdef ALU_SEQ_MULDIV_EN
            S_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                done     = 1'b1;
                state_d  = S_IDLE;
            end
`endif
            S_ERR: begin
                err     = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
